// File: rtl/serial_ripple_subtractor_pkg.sv
// Shared definitions for the bit-serial ripple subtractor: FSM state
// encodings and the default operand width.
package serial_ripple_subtractor_pkg;

    // Default operand/result width.
    localparam int DEFAULT_N = 4;

    // FSM state encodings.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_ripple_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
// The one combinational cell that the serial datapath reuses every cycle.
module full_subtractor
    import serial_ripple_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of a - b - bin.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~a & bin) | (b & bin);
    end

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial N-bit subtractor: computes A - B - Bin one bit per clock,
// LSB first, through one full_subtractor cell and a registered borrow.
//
// Handshake: start is a request sampled only in IDLE; the accepted start
// captures A, B and Bin. busy is high for the N processing cycles, and
// done pulses for one cycle with diff/bout valid. start is ignored (not
// queued) while busy or done; diff/bout hold until the next done.
module serial_ripple_subtractor
    import serial_ripple_subtractor_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic [1:0]   fsm_state
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;
    logic [N-1:0]  diff_sh;
    logic [N-1:0]  diff_next;
    logic          borrow;
    logic [CW-1:0] count;
    logic          d_bit;
    logic          bo_bit;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (bo_bit)
    );

    // Difference shift register after this cycle's bit enters at the MSB.
    always_comb begin
        diff_next = (diff_sh >> 1) | {d_bit, {(N-1){1'b0}}};
    end

    // FSM, datapath shift registers and registered outputs.
    // The final bit is folded straight into diff/bout on the last RUN edge
    // so that they are already valid in the DONE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh    <= A;
                        b_sh    <= B;
                        borrow  <= Bin;
                        diff_sh <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= diff_next;
                    borrow  <= bo_bit;
                    if (count == LAST) begin
                        diff  <= diff_next;
                        bout  <= bo_bit;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Current FSM state, exposed for observation.
    always_comb begin
        fsm_state = state;
    end

endmodule
